// File: rtl/snes_mem_pkg.sv
// Shared types and constants for the SNES cartridge memory path.
//   loader_state_t : issue FSM states of the ROM loader
//   rom_word_t     : one 16-bit SDRAM ROM word
//   rom_waddr_t    : 23-bit SDRAM ROM word address
//   rom_entry_t    : loader FIFO entry, {word address, word}
//   HDR_BYTES      : size of a copier header (used when SNES_LOADER_HDR_SKIP_EN is defined)
//   smear24()      : sets every bit below the highest set bit
package snes_mem_pkg;

  typedef enum logic {IDLE, WAIT} loader_state_t;

  typedef logic [15:0] rom_word_t;
  typedef logic [22:0] rom_waddr_t;

  typedef struct packed {
    rom_waddr_t addr;
    rom_word_t  data;
  } rom_entry_t;

  localparam int unsigned ENTRY_W   = 39;
  localparam int unsigned HDR_BYTES = 512;

  // 2^n-1 covering the given byte address.
  function automatic logic [23:0] smear24(input logic [23:0] a);
    logic [23:0] r;
    r = a;
    r = r | (r >> 1);
    r = r | (r >> 2);
    r = r | (r >> 4);
    r = r | (r >> 8);
    r = r | (r >> 16);
    return r;
  endfunction

endpackage

// File: rtl/snes_sync_fifo.sv
// Synchronous FIFO with registered pointers and an extra wrap bit per pointer.
// No pass-through: a word pushed into an empty FIFO is readable from the next cycle.
// Ports:
//   clk, reset          : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data     : write strobe and data (ignored when full)
//   pop                 : advance the read pointer (ignored when empty)
//   pop_data            : head entry
//   full, empty, count  : occupancy status
module snes_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 39
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/snes_rom_loader.sv
// Cartridge download feeder for the SDRAM ROM port. Packs the byte-serial ioctl stream into
// 16-bit words (low byte = even address), buffers them in a word FIFO and writes them to SDRAM
// over a toggle req/ack handshake. Tracks the loaded image size as a 2^n-1 address mask.
// Config macro: SNES_LOADER_HDR_SKIP_EN drops the first 512 bytes (copier header) and rebases
// every later address by -512.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   ioctl_download/wr/addr/dout : download stream from the IO controller
//   ioctl_wait                : backpressure, FIFO occupancy >= FIFO_DEPTH-2 (registered)
//   rom_addr/din/we           : SDRAM ROM write word address, data and write qualifier
//   rom_req, rom_req_ack      : toggle request / acknowledge
//   rom_mask                  : address mask of the loaded image
//   load_done                 : one-cycle pulse when a download has fully drained
module snes_rom_loader
  import snes_mem_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [23:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [22:0] rom_addr,
  output logic [15:0] rom_din,
  output logic        rom_we,
  output logic        rom_req,
  input  logic        rom_req_ack,
  output logic [23:0] rom_mask,
  output logic        load_done
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------------------------------------
  // Byte acceptance and address rebasing
  // ---------------------------------------------------------------------------------------------
  logic        accept;
  logic [23:0] eaddr;

`ifdef SNES_LOADER_HDR_SKIP_EN
  assign accept = ioctl_download && ioctl_wr && (ioctl_addr >= 24'(HDR_BYTES));
  assign eaddr  = ioctl_addr - 24'(HDR_BYTES);
`else
  assign accept = ioctl_download && ioctl_wr;
  assign eaddr  = ioctl_addr;
`endif

  logic download_q;
  logic dl_rise;
  logic dl_fall;

  assign dl_rise = ioctl_download && !download_q;
  assign dl_fall = !ioctl_download && download_q;

  // ---------------------------------------------------------------------------------------------
  // Byte packing: holder for one pending low byte, producing 0..2 words per cycle
  // ---------------------------------------------------------------------------------------------
  logic       hold_valid_q, hold_valid_d;
  logic [7:0] hold_byte_q, hold_byte_d;
  rom_waddr_t hold_addr_q, hold_addr_d;

  rom_entry_t new_word [2];
  logic [1:0] new_cnt;
  rom_entry_t flush_entry;

  assign flush_entry = '{addr: hold_addr_q, data: {8'h00, hold_byte_q}};

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_byte_d  = hold_byte_q;
    hold_addr_d  = hold_addr_q;
    new_word[0]  = '0;
    new_word[1]  = '0;
    new_cnt      = 2'd0;
    if (accept) begin
      if (!eaddr[0]) begin
        if (hold_valid_q) begin
          new_word[0] = flush_entry;
          new_cnt     = 2'd1;
        end
        hold_valid_d = 1'b1;
        hold_byte_d  = ioctl_dout;
        hold_addr_d  = eaddr[23:1];
      end else begin
        hold_valid_d = 1'b0;
        if (hold_valid_q && (hold_addr_q == eaddr[23:1])) begin
          new_word[0] = '{addr: eaddr[23:1], data: {ioctl_dout, hold_byte_q}};
          new_cnt     = 2'd1;
        end else if (hold_valid_q) begin
          // Stranded low byte of another word goes out first.
          new_word[0] = flush_entry;
          new_word[1] = '{addr: eaddr[23:1], data: {ioctl_dout, 8'h00}};
          new_cnt     = 2'd2;
        end else begin
          new_word[0] = '{addr: eaddr[23:1], data: {ioctl_dout, 8'h00}};
          new_cnt     = 2'd1;
        end
      end
    end else if (dl_fall && hold_valid_q) begin
      new_word[0]  = flush_entry;
      new_cnt      = 2'd1;
      hold_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Push staging: words wait here one cycle, then enter the FIFO one per cycle. A two-word
  // flush is only possible with an empty holder slot behind it, so two entries never overflow.
  // ---------------------------------------------------------------------------------------------
  rom_entry_t pend_q [2];
  rom_entry_t pend_d [2];
  logic [1:0] pend_cnt_q, pend_cnt_d;
  logic [1:0] pend_base;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  fifo_wdata;
  logic [ENTRY_W-1:0]  fifo_rdata;
  logic [CW-1:0]       fifo_count;
  rom_entry_t          fifo_head;

  assign fifo_push  = (pend_cnt_q != 2'd0) && !fifo_full;
  assign fifo_wdata = pend_q[0];
  assign fifo_head  = rom_entry_t'(fifo_rdata);

  always_comb begin
    pend_d[0] = pend_q[0];
    pend_d[1] = pend_q[1];
    pend_base = pend_cnt_q;
    if (fifo_push) begin
      pend_d[0] = pend_q[1];
      pend_base = pend_cnt_q - 2'd1;
    end
    if (new_cnt != 2'd0) pend_d[pend_base[0]] = new_word[0];
    if (new_cnt == 2'd2) pend_d[1] = new_word[1];
    pend_cnt_d = pend_base + new_cnt;
  end

  snes_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ---------------------------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------------------------
  loader_state_t state_q, state_d;
  rom_waddr_t    rom_addr_q, rom_addr_d;
  rom_word_t     rom_din_q, rom_din_d;
  logic          rom_we_q, rom_we_d;
  logic          rom_req_q, rom_req_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    rom_din_d  = rom_din_q;
    rom_we_d   = rom_we_q;
    rom_req_d  = rom_req_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && (rom_req_q == rom_req_ack)) begin
          rom_addr_d = fifo_head.addr;
          rom_din_d  = fifo_head.data;
          rom_we_d   = 1'b1;
          rom_req_d  = ~rom_req_q;
          fifo_pop   = 1'b1;
          state_d    = WAIT;
        end else if (fifo_empty && !ioctl_download) begin
          rom_we_d = 1'b0;
        end
      end
      WAIT: begin
        if (rom_req_ack == rom_req_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Mask, backpressure and completion
  // ---------------------------------------------------------------------------------------------
  logic [23:0] mask_q, mask_d;
  logic        wait_q, wait_d;
  logic        arm_q, arm_d;
  logic        done_q, done_d;

  always_comb begin
    mask_d = dl_rise ? 24'h0 : mask_q;
    if (accept) mask_d = mask_d | smear24(eaddr);

    wait_d = (fifo_count >= CW'(FIFO_DEPTH - 2));

    // Armed by the falling edge; fires once everything downstream is quiet.
    arm_d = arm_q;
    if (dl_fall) arm_d = 1'b1;
    if (dl_rise) arm_d = 1'b0;
    done_d = arm_q && !ioctl_download && !hold_valid_q && (pend_cnt_q == 2'd0) &&
             fifo_empty && (state_q == IDLE) && (rom_req_q == rom_req_ack);
    if (done_d) arm_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      download_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_byte_q  <= '0;
      hold_addr_q  <= '0;
      pend_q[0]    <= '0;
      pend_q[1]    <= '0;
      pend_cnt_q   <= '0;
      rom_addr_q   <= '0;
      rom_din_q    <= '0;
      rom_we_q     <= 1'b0;
      rom_req_q    <= 1'b0;
      mask_q       <= '0;
      wait_q       <= 1'b0;
      arm_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      download_q   <= ioctl_download;
      hold_valid_q <= hold_valid_d;
      hold_byte_q  <= hold_byte_d;
      hold_addr_q  <= hold_addr_d;
      pend_q[0]    <= pend_d[0];
      pend_q[1]    <= pend_d[1];
      pend_cnt_q   <= pend_cnt_d;
      rom_addr_q   <= rom_addr_d;
      rom_din_q    <= rom_din_d;
      rom_we_q     <= rom_we_d;
      rom_req_q    <= rom_req_d;
      mask_q       <= mask_d;
      wait_q       <= wait_d;
      arm_q        <= arm_d;
      done_q       <= done_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign rom_addr   = rom_addr_q;
  assign rom_din    = rom_din_q;
  assign rom_we     = rom_we_q;
  assign rom_req    = rom_req_q;
  assign rom_mask   = mask_q;
  assign load_done  = done_q;

endmodule

// File: tb/tb_snes_rom_loader.sv
// Bench for snes_rom_loader: directed downloads, a byte-level model of the expected SDRAM
// write sequence, an SDRAM ack responder with programmable delay, and literal checks.
module tb_snes_rom_loader;

  localparam int unsigned FIFO_DEPTH = 4;
`ifdef SNES_LOADER_HDR_SKIP_EN
  localparam int OFS = 512;
`else
  localparam int OFS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [23:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [22:0] rom_addr;
  logic [15:0] rom_din;
  logic        rom_we;
  logic        rom_req;
  logic        rom_req_ack;
  logic [23:0] rom_mask;
  logic        load_done;

  always #5 clk = ~clk;

  snes_rom_loader #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .rom_addr       (rom_addr),
    .rom_din        (rom_din),
    .rom_we         (rom_we),
    .rom_req        (rom_req),
    .rom_req_ack    (rom_req_ack),
    .rom_mask       (rom_mask),
    .load_done      (load_done)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired or event missing", name);
  endtask

  // ---------------------------------------------------------------------------------------------
  // Model: expected writes derived from the byte stream, {word addr[22:0], data[15:0]}
  // ---------------------------------------------------------------------------------------------
  logic [38:0] exp_q[$];
  logic [38:0] log_q[$];
  bit          m_held;
  logic [7:0]  m_byte;
  int          m_addr;
  int          m_max;

  function automatic logic [38:0] ent(input int waddr, input logic [15:0] d);
    logic [22:0] a;
    a = waddr[22:0];
    return {a, d};
  endfunction

  function automatic void model_byte(input int addr, input logic [7:0] d);
    int ea;
    if (addr < OFS) return;
    ea = addr - OFS;
    if (ea > m_max) m_max = ea;
    if (ea % 2 == 0) begin
      if (m_held) exp_q.push_back(ent(m_addr / 2, {8'h00, m_byte}));
      m_held = 1;
      m_byte = d;
      m_addr = ea;
    end else begin
      if (m_held && (m_addr / 2 == ea / 2)) begin
        exp_q.push_back(ent(ea / 2, {d, m_byte}));
      end else begin
        if (m_held) exp_q.push_back(ent(m_addr / 2, {8'h00, m_byte}));
        exp_q.push_back(ent(ea / 2, {d, 8'h00}));
      end
      m_held = 0;
    end
  endfunction

  function automatic void model_end();
    if (m_held) exp_q.push_back(ent(m_addr / 2, {8'h00, m_byte}));
    m_held = 0;
  endfunction

  function automatic logic [23:0] model_mask();
    int m;
    m = 0;
    while (m < m_max) m = m * 2 + 1;
    return m[23:0];
  endfunction

  // ---------------------------------------------------------------------------------------------
  // SDRAM ack responder
  // ---------------------------------------------------------------------------------------------
  int ack_delay = 0;

  initial begin
    int cnt;
    cnt = 0;
    rom_req_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        rom_req_ack = 1'b0;
        cnt = 0;
      end else if (rom_req !== rom_req_ack) begin
        if (cnt >= ack_delay) begin
          rom_req_ack = rom_req;
          cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------------------------
  logic        prev_req = 1'b0;
  logic [38:0] last_issue = '0;
  logic [38:0] cur;
  int          done_cnt = 0;
  bit          wait_seen = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (load_done === 1'b1) done_cnt++;
      if (ioctl_wait === 1'b1) wait_seen = 1;
      if (rom_req !== prev_req) begin
        log_q.push_back({rom_addr, rom_din});
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want none", rom_addr,
                   rom_din);
        end else begin
          cur = exp_q.pop_front();
          check("write_addr", rom_addr, cur[38:16]);
          check("write_data", rom_din, cur[15:0]);
          check("write_we", rom_we, 1);
        end
        prev_req   = rom_req;
        last_issue = {rom_addr, rom_din};
      end else if (rom_req !== rom_req_ack) begin
        check("hold_stable", {rom_we, rom_addr, rom_din}, {1'b1, last_issue});
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------------------------
  int done_base;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    m_held = 0;
    m_max = 0;
    log_q.delete();
    done_base = done_cnt;
    tick(1);
  endtask

  task automatic send(input int a, input logic [7:0] d);
    int g;
    g = 0;
    while (ioctl_wait && g < 500) begin
      tick(1);
      g++;
    end
    if (g >= 500) fail_now("ioctl_wait_release");
    ioctl_addr = a[23:0];
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    model_byte(a, d);
    tick(1);
    ioctl_wr   = 1'b0;
  endtask

  task automatic end_dl();
    int g;
    ioctl_download = 1'b0;
    model_end();
    g = 0;
    while (done_cnt == done_base && g < 1000) begin
      tick(1);
      g++;
    end
    if (g >= 1000) fail_now("load_done_timeout");
    tick(5);
    check("load_done_pulses", done_cnt - done_base, 1);
    check("writes_outstanding", exp_q.size(), 0);
    check("rom_mask_model", rom_mask, model_mask());
    check("rom_we_idle", rom_we, 0);
    check("ioctl_wait_idle", ioctl_wait, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------------------------
  initial begin
    int g;
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    tick(3);
    reset = 1'b0;

    // Reset values
    check("rst_ioctl_wait", ioctl_wait, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_rom_din", rom_din, 0);
    check("rst_rom_we", rom_we, 0);
    check("rst_rom_req", rom_req, 0);
    check("rst_rom_mask", rom_mask, 0);
    check("rst_load_done", load_done, 0);

    // Sequential bytes, immediate ack
    start_dl();
    send(OFS + 0, 8'h11);
    send(OFS + 1, 8'h22);
    send(OFS + 2, 8'h33);
    send(OFS + 3, 8'h44);
    end_dl();
    check("t1_count", log_q.size(), 2);
    check("t1_w0", log_q[0], {23'd0, 16'h2211});
    check("t1_w1", log_q[1], {23'd1, 16'h4433});
    check("t1_mask", rom_mask, 24'h000003);

    // Slow ack, back-to-back bytes, backpressure
    ack_delay = 20;
    wait_seen = 0;
    start_dl();
    for (int i = 0; i < 8; i++) send(OFS + i, 8'hA0 + 8'(i));
    end_dl();
    ack_delay = 0;
    check("t2_wait_seen", wait_seen, 1);
    check("t2_count", log_q.size(), 4);
    check("t2_w0", log_q[0], {23'd0, 16'hA1A0});
    check("t2_w3", log_q[3], {23'd3, 16'hA7A6});

    // Odd-length image
    start_dl();
    for (int i = 0; i < 4; i++) send(OFS + i, 8'h10 + 8'(i));
    send(OFS + 4, 8'hAB);
    end_dl();
    check("t3_count", log_q.size(), 3);
    check("t3_last", log_q[2], {23'd2, 16'h00AB});
    check("t3_mask", rom_mask, 24'h000007);

    // Non-contiguous bytes
    start_dl();
    send(OFS + 6, 8'h55);
    send(OFS + 9, 8'h66);
    end_dl();
    check("t4_count", log_q.size(), 2);
    check("t4_w0", log_q[0], {23'd3, 16'h0055});
    check("t4_w1", log_q[1], {23'd4, 16'h6600});
    check("t4_mask", rom_mask, 24'h00000F);

`ifdef SNES_LOADER_HDR_SKIP_EN
    // Copier header skip
    start_dl();
    send(24'h1FF, 8'h01);
    send(24'h200, 8'hCD);
    send(24'h201, 8'hEF);
    end_dl();
    check("hdr_count", log_q.size(), 1);
    check("hdr_w0", log_q[0], {23'd0, 16'hEFCD});
    check("hdr_mask", rom_mask, 24'h000001);
`endif

    // Reset while a request is outstanding
    ack_delay = 20;
    start_dl();
    for (int i = 0; i < 6; i++) send(OFS + i, 8'hC0 + 8'(i));
    g = 0;
    while (rom_req === rom_req_ack && g < 200) begin
      tick(1);
      g++;
    end
    if (g >= 200) fail_now("t5_request_outstanding");
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick(1);
    check("t5_rom_req", rom_req, 0);
    check("t5_rom_we", rom_we, 0);
    check("t5_ioctl_wait", ioctl_wait, 0);
    check("t5_load_done", load_done, 0);
    check("t5_rom_mask", rom_mask, 0);
    reset = 1'b0;
    exp_q.delete();
    m_held = 0;
    ack_delay = 0;
    log_q.delete();
    tick(30);
    check("t5_no_stale_writes", log_q.size(), 0);

    start_dl();
    send(OFS + 0, 8'h91);
    send(OFS + 1, 8'h92);
    send(OFS + 2, 8'h93);
    send(OFS + 3, 8'h94);
    end_dl();
    check("t5_restart_count", log_q.size(), 2);
    check("t5_restart_w0", log_q[0], {23'd0, 16'h9291});
    check("t5_restart_w1", log_q[1], {23'd1, 16'h9493});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
